// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// fixed-latency long EX ops, HALT latch and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned REG_ADDR_W     = 4,
    parameter int unsigned LONG_OP_CYCLES = 4,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   id_is_long,
    input  logic                   id_is_halt,
    input  logic                   ex_valid,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   branch_taken_ex,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   ex_hold,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN,
        LONG_BUSY,
        HALTED
    } state_t;

    localparam logic [7:0] BUSY_INIT = 8'(LONG_OP_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [7:0]             busy_cnt_q, busy_cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
    logic                   load_use;

    // r0 is hardwired zero, so a load into it never creates a dependency
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d      = state_q;
        busy_cnt_d   = busy_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        halted       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (branch_taken_ex) begin
                    // ID holds a wrong-path instruction: flush beats every stall source
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (id_valid && id_is_halt) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = HALTED;
                end else if (id_valid && id_is_long) begin
                    busy_cnt_d = BUSY_INIT;
                    state_d    = LONG_BUSY;
                end
            end
            LONG_BUSY: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                ex_hold     = 1'b1;
                busy_cnt_d  = busy_cnt_q - 8'd1;
                if (busy_cnt_q <= 8'd1) begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
            ex_hold      = 1'b0;
            halted       = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if ((state_q != HALTED) && !pc_write && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            busy_cnt_q    <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_cnt_q    <= busy_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// randomized traffic against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    localparam int unsigned LONG = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_is_long, id_is_halt;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_mem_read, branch_taken_ex;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, halted;
    logic [15:0] stall_count;
    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, ex_hold4, halted4;
    logic [3:0]  stall_count4;

    int checks = 0;
    int errors = 0;

    // model state: remaining EX hold cycles, halt latch, expected counters
    int m_busy;
    bit m_halted;
    int m_cnt16;
    int m_cnt4;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_ADDR_W(4), .LONG_OP_CYCLES(LONG), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_is_long(id_is_long), .id_is_halt(id_is_halt),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .halted(halted),
        .stall_count(stall_count)
    );

    hazard_stall_ctrl #(.REG_ADDR_W(4), .LONG_OP_CYCLES(LONG), .STALL_CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_is_long(id_is_long), .id_is_halt(id_is_halt),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
        .id_ex_bubble(id_ex_bubble4), .ex_hold(ex_hold4), .halted(halted4),
        .stall_count(stall_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_is_long = 0; id_is_halt = 0; ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
        branch_taken_ex = 0;
    endtask

    task automatic chk_outs(input string tag, input bit pw, input bit iw, input bit fl,
                            input bit bub, input bit hold, input bit hlt);
        chk({tag, ".pc_write"},     {31'd0, pc_write},     {31'd0, pw});
        chk({tag, ".if_id_write"},  {31'd0, if_id_write},  {31'd0, iw});
        chk({tag, ".if_id_flush"},  {31'd0, if_id_flush},  {31'd0, fl});
        chk({tag, ".id_ex_bubble"}, {31'd0, id_ex_bubble}, {31'd0, bub});
        chk({tag, ".ex_hold"},      {31'd0, ex_hold},      {31'd0, hold});
        chk({tag, ".halted"},       {31'd0, halted},       {31'd0, hlt});
        chk({tag, ".stall_count"},  {16'd0, stall_count},  m_cnt16);
        chk({tag, ".stall_count4"}, {28'd0, stall_count4}, m_cnt4);
    endtask

    // Called just after a falling edge with inputs set: checks, then advances one cycle.
    task automatic step(input string tag);
        bit lu, pw, iw, fl, bub, hold, hlt;
        #1;
        lu = ex_valid && ex_mem_read && (ex_rd != 4'd0) && id_valid &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        pw = 1; iw = 1; fl = 0; bub = 0; hold = 0; hlt = 0;
        if (m_halted) begin
            pw = 0; iw = 0; bub = 1; hlt = 1;
        end else if (m_busy > 0) begin
            pw = 0; iw = 0; hold = 1;
        end else if (branch_taken_ex) begin
            fl = 1; bub = 1;
        end else if (lu || (id_valid && id_is_halt)) begin
            pw = 0; iw = 0; bub = 1;
        end
        chk_outs(tag, pw, iw, fl, bub, hold, hlt);
        @(posedge clk);
        if (!m_halted && !pw) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (m_halted) begin
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (!branch_taken_ex && !lu) begin
            if (id_valid && id_is_halt) m_halted = 1;
            else if (id_valid && id_is_long) m_busy = LONG - 1;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted just after a falling edge, held across one rising edge.
    task automatic do_reset(input string tag);
        reset = 1;
        #1;
        m_busy = 0; m_halted = 0; m_cnt16 = 0; m_cnt4 = 0;
        chk_outs({tag, ".rst"}, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_outs({tag, ".rst_held"}, 0, 0, 0, 1, 0, 0);
        reset = 0;
    endtask

    task automatic set_load_use(input logic [3:0] rd);
        ex_valid = 1; ex_mem_read = 1; ex_rd = rd;
        id_valid = 1; id_rs2 = rd; id_uses_rs2 = 1;
    endtask

    initial begin
        idle();
        reset = 1;
        m_busy = 0; m_halted = 0; m_cnt16 = 0; m_cnt4 = 0;
        @(negedge clk);
        do_reset("init");

        // load-use: one stall cycle, then full advance
        set_load_use(4'd3);
        step("lu_stall");
        idle(); id_valid = 1; id_rs2 = 4'd3; id_uses_rs2 = 1;
        step("lu_adv");
        chk("lu_count", {16'd0, stall_count}, 32'd1);

        // load into r0 never stalls
        do_reset("r0");
        ex_valid = 1; ex_mem_read = 1; ex_rd = 0;
        id_valid = 1; id_rs1 = 0; id_uses_rs1 = 1; id_rs2 = 0; id_uses_rs2 = 1;
        step("r0_nostall");
        chk("r0_count", {16'd0, stall_count}, 32'd0);

        // branch beats load-use and halt
        idle(); set_load_use(4'd5); id_is_halt = 1; branch_taken_ex = 1;
        step("br_win");
        idle(); id_valid = 1;
        step("br_after");

        // long op: issue, three hold cycles, back to RUN
        do_reset("long");
        id_valid = 1; id_is_long = 1;
        step("long_issue");
        idle();
        for (int i = 0; i < 3; i++) step("long_busy");
        id_valid = 1;
        step("long_done");
        chk("long_count", {16'd0, stall_count}, 32'd3);

        // reset during second busy cycle
        id_is_long = 1;
        step("long2_issue");
        idle();
        step("long2_busy1");
        do_reset("long2_rst");
        id_valid = 1;
        step("long2_run");

        // halt: latched for 100 cycles regardless of inputs
        do_reset("halt");
        id_valid = 1; id_is_halt = 1;
        step("halt_issue");
        for (int i = 0; i < 100; i++) begin
            branch_taken_ex = i[0];
            id_is_long = 1'($urandom_range(0, 1));
            set_load_use(4'($urandom_range(1, 15)));
            step("halt_hold");
        end
        chk("halt_count", {16'd0, stall_count}, 32'd1);
        do_reset("halt_clr");
        idle();
        step("halt_exit");

        // saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            set_load_use(4'd7);
            step("sat");
        end
        idle();
        step("sat_end");
        chk("sat_count4", {28'd0, stall_count4}, 32'd15);
        chk("sat_count16", {16'd0, stall_count}, 32'd20);

        // randomized traffic
        do_reset("rand");
        for (int i = 0; i < 2000; i++) begin
            id_valid        = 1'($urandom_range(0, 3) != 0);
            id_rs1          = 4'($urandom_range(0, 3));
            id_rs2          = 4'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            id_is_long      = 1'($urandom_range(0, 9) == 0);
            id_is_halt      = 1'($urandom_range(0, 49) == 0);
            ex_valid        = 1'($urandom_range(0, 3) != 0);
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_rd           = 4'($urandom_range(0, 3));
            branch_taken_ex = 1'($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) do_reset("rand_rst");
            else step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage 19-bit CPU.
- Drives the PC write enable, the IF/ID register write enable (IF_IDwrite) and flush, the ID/EX bubble, and the EX hold.
- Handles three cases:
  - load-use stalls
  - taken-branch flushes (branch resolved in EX)
  - fixed-latency multi-cycle EX operations
- Latches a HALT instruction and keeps a saturating stall-cycle counter.

Parameters:
- REG_ADDR_W, 4: register-address width (16 architectural registers; r0 is hardwired zero).
- LONG_OP_CYCLES, 4: total EX occupancy of a long op, in cycles. Legal range 2..255.
- STALL_CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real (non-bubble) instruction.
- id_rs1  in  REG_ADDR_W  ID source register 1.
- id_rs2  in  REG_ADDR_W  ID source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_is_long  in  1  ID instruction is a multi-cycle EX op.
- id_is_halt  in  1  ID instruction is HALT.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_ADDR_W  EX destination register.
- branch_taken_ex  in  1  branch in EX resolved taken; PC mux selects target this cycle.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID register write enable (IF_IDwrite).
- if_id_flush  out  1  top level muxes a NOP into next_instruction when set.
- id_ex_bubble  out  1  ID/EX loads a NOP (control bits zeroed) instead of ID contents.
- ex_hold  out  1  ID/EX and EX/MEM hold; the long op stays in EX.
- halted  out  1  core halted.
- stall_count  out  STALL_CNT_W  saturating count of stalled cycles.

Behaviour:
- States: RUN, LONG_BUSY, HALTED. Down-counter busy_cnt is 8 bits.
- Reset (async, effective immediately while asserted):
  - State: state=RUN, busy_cnt=0, stall_count=0.
  - Outputs while reset is high: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, ex_hold=0, halted=0.
  - Reset mid-LONG_BUSY or in HALTED returns to RUN on the first edge after deassertion.
- Hazard terms (combinational):
  - load_use = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Outputs in RUN are Mealy (same-cycle); outputs in LONG_BUSY and HALTED are Moore.
- RUN, priority highest first:
  1. branch_taken_ex: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. State stays RUN. Overrides load_use, id_is_long and id_is_halt, because the ID instruction is wrong-path.
  2. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1. State stays RUN. This is a 1-cycle stall: the next cycle sees a bubble in EX, so load_use clears.
  3. id_valid & id_is_halt: pc_write=0, if_id_write=0, id_ex_bubble=1. Next state HALTED.
  4. id_valid & id_is_long: normal advance this cycle (the long op enters EX). busy_cnt <= LONG_OP_CYCLES-1; next state LONG_BUSY.
  5. Otherwise: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, ex_hold=0.
- LONG_BUSY:
  - Outputs: pc_write=0, if_id_write=0, ex_hold=1, id_ex_bubble=0.
  - busy_cnt decrements each cycle. When busy_cnt==1, next state is RUN, so EX is occupied exactly LONG_OP_CYCLES cycles total.
  - branch_taken_ex, id_is_halt and load_use are ignored in this state (EX holds a non-branch, non-load op).
- HALTED:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, halted=1. All inputs are ignored.
  - Exit only via reset.
- stall_count:
  - Increments by 1 on every rising edge where pc_write==0 and the state is RUN or LONG_BUSY.
  - Excluded: HALTED cycles and reset.
  - Saturates at all-ones with no wrap.
- Width rule: all register comparisons are full REG_ADDR_W equality. ex_rd==0 never creates a hazard.

Test Plan:
- Load-use: EX `lw r3` (ex_valid=1, ex_mem_read=1, ex_rd=3); ID add with id_rs2=3, id_uses_rs2=1 → exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (ex_valid=0) full advance; stall_count=1.
- Load to r0: same stimulus with ex_rd=0, id_rs1=0 → no stall; pc_write=1 and stall_count=0.
- Branch beats hazard: branch_taken_ex=1 together with a load_use condition and id_is_halt=1 → pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; halted stays 0; state RUN.
- Long op, LONG_OP_CYCLES=4: id_is_long=1 → issue cycle advances, then exactly 3 cycles of ex_hold=1 and pc_write=0, then RUN; stall_count=3. Reset asserted during the 2nd busy cycle → outputs immediately take reset values; RUN after release.
- Halt: id_valid=1, id_is_halt=1 → halted=1 from the next cycle, held for 100 cycles regardless of branch_taken_ex toggling; stall_count unchanged over those cycles; reset clears halted to 0.
- Saturation, STALL_CNT_W=4: 20 consecutive load-use stalls (alternate the bubble cycle by holding the load-use condition) → stall_count stops at 15.
